jtbubl_gfx_romarb: RTL and testbench
====================================

# jtbubl_gfx_romarb

Two-client arbiter for the 32-bit graphics ROM slot of the SDRAM controller. It serves the object/tile pixel fetcher of the graphics block and a second requester, such as a prefetch engine or a debug reader, through one `rom_addr`/`rom_cs`/`rom_ok` port. It sequences each transaction, discards the stale `rom_ok` that follows an address change, and aborts cleanly at line blanking.

## Interface
- `AW`, 18: ROM word-address width.
- `DW`, 32: ROM data width.
- `rst` input 1: reset, asynchronous, active-high.
- `clk` input 1: clock; all logic runs on it.
- `flush` input 1: abort request; tied to `~LHBL` by the parent.
- `c0_cs` input 1: client 0 request, held until `c0_ok`.
- `c0_addr` input AW: client 0 word address, stable while `c0_cs` is high.
- `c0_ok` output 1: one-cycle done pulse for client 0.
- `c0_data` output DW: client 0 data, held until client 0 is next served.
- `c1_cs`, `c1_addr`, `c1_ok`, `c1_data`: same as client 0, for client 1.
- `rom_cs` output 1: SDRAM request.
- `rom_addr` output AW: SDRAM address; registered.
- `rom_data` input DW: SDRAM data.
- `rom_ok` input 1: SDRAM data valid; may stay high from the previous address for one cycle.

## Operation
- FSM states: `IDLE`, `ISSUE`, `WAIT`, `GAP`.
- `IDLE`:
  - If any `cN_cs` is high, latch the granted client id and `rom_addr`, set `rom_cs`=1, go to `ISSUE`.
  - Round-robin: with both requesting, grant the client not granted last. Only one requesting: grant it.
- `ISSUE`: ignore `rom_ok` (stale-ok blanking), go to `WAIT`.
- `WAIT`:
  - On `rom_ok`, register `rom_data` into the granted `cN_data`.
  - Pulse `cN_ok` on the next cycle, drop `rom_cs`, update last-granted, go to `GAP`.
- `GAP`: one cycle in which `cN_cs` is ignored. This lets the client drop or change its request after `cN_ok`. Then go to `IDLE`.
- `flush` high, any state:
  - Next state is `IDLE`, `rom_cs`=0, no `cN_ok` issued.
  - Data registers and last-granted are unchanged.
  - A response arriving after the flush is discarded.
- Changing `cN_addr` mid-transaction is a client protocol violation; the arbiter serves the latched address.
- No watchdog: `WAIT` holds indefinitely until `rom_ok` or `flush`.

## Timing
- Reset values:
  - State `IDLE`, `rom_cs`=0, `rom_addr`=0.
  - `c0_ok`=`c1_ok`=0, `c0_data`=`c1_data`=0.
  - Last-granted = client 1, so client 0 wins the first tie.
- Minimum miss latency, `cN_cs` first sampled high at cycle 0:
  - `rom_cs` high at cycle 1.
  - `rom_ok` accepted from cycle 2.
  - `cN_ok` at cycle 3.
- A client holding `cs` continuously is re-served no sooner than 2 cycles after its `ok`. Competing clients alternate.
- `rom_ok` and `flush` in the same cycle: `flush` wins.
- Reset mid-transaction: immediate return to reset values.

## Configuration
- `JTBUBL_ROMARB_CACHE_EN` defined:
  - Each client keeps a valid bit and a tag holding its last served address.
  - A request whose address matches a valid tag is a hit and is served from `IDLE` with `cN_ok` on the next cycle. The FSM goes to `GAP`, `rom_cs` stays 0, and last-granted is unchanged.
  - A hit takes priority over a miss from the other client in the same cycle.
  - `rst` clears both valid bits; `flush` does not.
  - A flushed miss leaves the tag untouched.
- Macro undefined: every request goes to SDRAM and there is no tag logic.

## Structure
- Shared package `jtbubl_gfx_pkg`: FSM state encodings (`ST_IDLE`, `ST_ISSUE`, `ST_WAIT`, `ST_GAP`) and client-id constants.
- Sub-module `jtbubl_romarb_tag`, one instance per client: valid/tag/data register with hit compare. Present only when `JTBUBL_ROMARB_CACHE_EN` is defined.
- Top level holds the FSM, the round-robin pointer and the output muxing.

## Test plan
- Single miss: `c0_cs`=1, `c0_addr`=0x01234, SDRAM model returns 0xDEADBEEF 4 cycles after `rom_cs` → `rom_addr`=0x01234, `c0_ok` one cycle wide, `c0_data`=0xDEADBEEF, `c1_ok` never high.
- Stale ok: `rom_ok` held high from the prior access during `ISSUE` → ignored; data latched only on the `rom_ok` in `WAIT`.
- Contention: both clients request continuously → grant order 0,1,0,1 and `rom_cs` low for ≥1 cycle between transactions.
- Flush: `flush` raised 2 cycles into `WAIT`, then `rom_ok` → no `cN_ok`, `rom_cs`=0 next cycle, `c0_data` unchanged; the same request is re-issued after `flush` falls.
- Cache, macro on: client 1 reads 0x3FFFF twice → second read has `rom_cs` never high and `c1_ok` 1 cycle after request with the same data. After `rst`, the same address misses.
- Reset mid-`WAIT`: `rst` pulse → all outputs at reset values; next tie goes to client 0.

Source files
------------

// File: rtl/jtbubl_gfx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtbubl_gfx_pkg                                                       |
// | Shared types for the graphics ROM arbiter: FSM states, client ids.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package jtbubl_gfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } romarb_state_t;

  localparam logic CLI_0 = 1'b0;
  localparam logic CLI_1 = 1'b1;
  localparam int   NCLI  = 2;

  // Both requesting: hand the slot to the client that did not win last time.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1] ? CLI_1 : CLI_0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtbubl_romarb_tag.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtbubl_romarb_tag                                                    |
// | Per-client last-word cache: valid bit, address tag, data, hit test.  |
// | Built only with JTBUBL_ROMARB_CACHE_EN.                              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`ifdef JTBUBL_ROMARB_CACHE_EN
module jtbubl_romarb_tag #(
  parameter int AW = 18,
  parameter int DW = 32
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          wr,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic          hit,
  output logic [DW-1:0] data
);

  logic          r_valid;
  logic [AW-1:0] r_tag;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (wr) begin
      r_valid <= 1'b1;
      r_tag   <= wr_addr;
      r_data  <= wr_data;
    end
  end

  assign hit  = r_valid && (r_tag == rd_addr);
  assign data = r_data;

endmodule
`endif
`default_nettype wire

// File: rtl/jtbubl_gfx_romarb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtbubl_gfx_romarb                                                    |
// | Two-client round-robin arbiter for the 32-bit graphics ROM slot,     |
// | with stale-ok blanking and flush abort. Optional last-word cache     |
// | per client when JTBUBL_ROMARB_CACHE_EN is defined.                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module jtbubl_gfx_romarb #(
  parameter int AW = 18,
  parameter int DW = 32
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          flush,
  input  logic          c0_cs,
  input  logic [AW-1:0] c0_addr,
  output logic          c0_ok,
  output logic [DW-1:0] c0_data,
  input  logic          c1_cs,
  input  logic [AW-1:0] c1_addr,
  output logic          c1_ok,
  output logic [DW-1:0] c1_data,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok
);

  import jtbubl_gfx_pkg::*;

  romarb_state_t r_state, w_next;
  logic          r_gnt, r_last, w_pick;
  logic          w_issue, w_done, w_hit_go;
  logic [1:0]    w_req, w_hit, r_ok;
  logic          r_rom_cs;
  logic [AW-1:0] r_rom_addr;
  logic [AW-1:0] w_caddr [NCLI];
  logic [DW-1:0] w_data  [NCLI];

  assign w_req      = {c1_cs, c0_cs};
  assign w_caddr[0] = c0_addr;
  assign w_caddr[1] = c1_addr;

  always_comb begin
    w_next   = r_state;
    w_pick   = r_last;
    w_issue  = 1'b0;
    w_done   = 1'b0;
    w_hit_go = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_hit) begin
          w_pick   = rr_pick(w_hit, r_last);
          w_hit_go = 1'b1;
          w_next   = ST_GAP;
        end else if (|w_req) begin
          w_pick  = rr_pick(w_req, r_last);
          w_issue = 1'b1;
          w_next  = ST_ISSUE;
        end
      end
      // rom_ok here may still belong to the previous address
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT: begin
        if (rom_ok) begin
          w_done = 1'b1;
          w_next = ST_GAP;
        end
      end
      ST_GAP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (flush) begin
      w_next   = ST_IDLE;
      w_issue  = 1'b0;
      w_done   = 1'b0;
      w_hit_go = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rom_cs   <= 1'b0;
      r_rom_addr <= '0;
      r_gnt      <= CLI_0;
      r_last     <= CLI_1;
      r_ok       <= '0;
    end else begin
      r_state  <= w_next;
      r_rom_cs <= (w_next == ST_ISSUE) || (w_next == ST_WAIT);
      r_ok     <= '0;
      if (w_issue) begin
        r_gnt      <= w_pick;
        r_rom_addr <= w_caddr[w_pick];
      end
      if (w_done) begin
        r_ok[r_gnt] <= 1'b1;
        r_last      <= r_gnt;
      end
      if (w_hit_go) r_ok[w_pick] <= 1'b1;
    end
  end

`ifdef JTBUBL_ROMARB_CACHE_EN
  logic [1:0] w_tag_hit;

  for (genvar gi = 0; gi < NCLI; gi++) begin : g_tag
    jtbubl_romarb_tag #(
      .AW (AW),
      .DW (DW)
    ) u_tag (
      .rst     (rst),
      .clk     (clk),
      .wr      (w_done && (r_gnt == 1'(gi))),
      .wr_addr (r_rom_addr),
      .wr_data (rom_data),
      .rd_addr (w_caddr[gi]),
      .hit     (w_tag_hit[gi]),
      .data    (w_data[gi])
    );
  end

  assign w_hit = w_tag_hit & w_req;
`else
  logic [DW-1:0] r_data [NCLI];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
    end else if (w_done) begin
      r_data[r_gnt] <= rom_data;
    end
  end

  assign w_data[0] = r_data[0];
  assign w_data[1] = r_data[1];
  assign w_hit     = 2'b00;
`endif

  assign c0_ok    = r_ok[0];
  assign c1_ok    = r_ok[1];
  assign c0_data  = w_data[0];
  assign c1_data  = w_data[1];
  assign rom_cs   = r_rom_cs;
  assign rom_addr = r_rom_addr;

endmodule
`default_nettype wire

// File: tb/tb_jtbubl_gfx_romarb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_jtbubl_gfx_romarb                                                 |
// | Self-checking bench: vector table, directed corner sequences and a   |
// | randomized phase against a transaction-level reference model.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_jtbubl_gfx_romarb;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        c0_cs, c1_cs, c0_ok, c1_ok;
  logic [17:0] c0_addr, c1_addr, rom_addr;
  logic [31:0] c0_data, c1_data, rom_data;
  logic        rom_cs, rom_ok;

  // SDRAM model controls
  logic        sd_auto, sd_fixed, sd_fix_stale;
  int          sd_fix_dly;
  logic [31:0] sd_fix_data;
  logic        auto_ok, man_ok;
  logic [31:0] auto_data, man_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rom_ok   = sd_auto ? auto_ok   : man_ok;
  assign rom_data = sd_auto ? auto_data : man_data;

  jtbubl_gfx_romarb #(.AW(18), .DW(32)) dut (
    .rst      (rst),
    .clk      (clk),
    .flush    (flush),
    .c0_cs    (c0_cs),
    .c0_addr  (c0_addr),
    .c0_ok    (c0_ok),
    .c0_data  (c0_data),
    .c1_cs    (c1_cs),
    .c1_addr  (c1_addr),
    .c1_ok    (c1_ok),
    .c1_data  (c1_data),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok)
  );

  function automatic logic [31:0] model_data(input logic [17:0] a);
    return {a[9:0], 4'h9, a} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired, got no response expected one", nm);
  endtask

  // SDRAM: data after a delay counted from the first rom_cs cycle of an
  // address, optionally preceded by a stale garbage ok on that first cycle.
  initial begin : sdram
    logic        busy, stale;
    logic [17:0] a;
    int          cnt, dly;
    auto_ok = 1'b0; auto_data = '0;
    busy = 1'b0; stale = 1'b0; a = '0; cnt = 0; dly = 1;
    forever begin
      @(negedge clk);
      auto_ok = 1'b0;
      if (rom_cs) begin
        if (!busy || rom_addr != a) begin
          busy  = 1'b1;
          a     = rom_addr;
          cnt   = 0;
          dly   = sd_fixed ? sd_fix_dly : int'($urandom_range(1, 4));
          stale = sd_fixed ? sd_fix_stale : ($urandom_range(0, 1) == 1);
        end else begin
          cnt++;
        end
        if (cnt == 0 && stale) begin
          auto_ok = 1'b1; auto_data = 32'hBAD0_BAD0;
        end
        if (cnt == dly) begin
          auto_ok = 1'b1; auto_data = sd_fixed ? sd_fix_data : model_data(rom_addr);
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  // One request from one client; reports what the ports did over 30 cycles.
  task automatic txn(input int cli, input logic [17:0] a, output int okc,
                     output logic [31:0] d, output int nok, output int nother,
                     output logic rs1, output logic [17:0] ra1, output int rs_hi);
    okc = -1; d = '0; nok = 0; nother = 0; rs1 = 1'b0; ra1 = '0; rs_hi = 0;
    @(negedge clk);
    if (cli == 0) begin c0_addr = a; c0_cs = 1'b1; end
    else          begin c1_addr = a; c1_cs = 1'b1; end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin rs1 = rom_cs; ra1 = rom_addr; end
      if (rom_cs) rs_hi++;
      if (cli == 0 ? c0_ok : c1_ok) begin
        nok++;
        if (okc < 0) begin okc = k; d = (cli == 0) ? c0_data : c1_data; end
        c0_cs = 1'b0; c1_cs = 1'b0;
      end
      if (cli == 0 ? c1_ok : c0_ok) nother++;
    end
    c0_cs = 1'b0; c1_cs = 1'b0;
  endtask

  typedef struct {
    int          cli;
    logic [17:0] addr;
    int          dly;
    bit          stale;
    logic [31:0] rdata;
    int          exp_ok;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin : main
    int          okc, nok, nother, rs_hi, nrise, nord;
    logic        rs1, prev_rs, seen;
    logic [17:0] ra1;
    logic [31:0] d, d0;
    int          order[4];
    logic        pend[2];
    int          start[2], byp[2];
    logic [17:0] raddr[2];
`ifdef JTBUBL_ROMARB_CACHE_EN
    logic        cvalid[2];
    logic [17:0] ctag[2];
`endif

    vecs[0] = '{0, 18'h01234, 4, 1'b0, 32'hDEAD_BEEF, 6, 32'hDEAD_BEEF};
    vecs[1] = '{1, 18'h3FFFF, 1, 1'b1, 32'h0F0F_1234, 3, 32'h0F0F_1234};
    vecs[2] = '{0, 18'h00000, 2, 1'b1, 32'hCAFE_F00D, 4, 32'hCAFE_F00D};
    vecs[3] = '{1, 18'h15555, 6, 1'b0, 32'h8000_0001, 8, 32'h8000_0001};
    vecs[4] = '{0, 18'h2AAAA, 3, 1'b1, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFF};

    rst = 1'b1; flush = 1'b0;
    c0_cs = 1'b0; c1_cs = 1'b0; c0_addr = '0; c1_addr = '0;
    sd_auto = 1'b1; sd_fixed = 1'b1; sd_fix_stale = 1'b0; sd_fix_dly = 1;
    sd_fix_data = '0; man_ok = 1'b0; man_data = '0;

    repeat (3) @(negedge clk);
    chk("reset_rom_cs", rom_cs, 0);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_c0_ok", c0_ok, 0);
    chk("reset_c1_ok", c1_ok, 0);
    chk("reset_c0_data", c0_data, 0);
    chk("reset_c1_data", c1_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table: single misses with fixed latency and optional stale ok.
    for (int v = 0; v < 5; v++) begin
      sd_fixed = 1'b1; sd_fix_dly = vecs[v].dly;
      sd_fix_stale = vecs[v].stale; sd_fix_data = vecs[v].rdata;
      txn(vecs[v].cli, vecs[v].addr, okc, d, nok, nother, rs1, ra1, rs_hi);
      chk("vec_rom_cs_cycle1", rs1, 1);
      chk("vec_rom_addr", ra1, vecs[v].addr);
      chk("vec_ok_cycle", okc, vecs[v].exp_ok);
      chk("vec_data", d, vecs[v].exp_data);
      chk("vec_ok_width", nok, 1);
      chk("vec_other_ok", nother, 0);
    end

    // Reset in the middle of WAIT.
    sd_auto = 1'b0; man_ok = 1'b0;
    @(negedge clk); c1_addr = 18'h00400; c1_cs = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rom_cs", rom_cs, 0);
    chk("midrst_rom_addr", rom_addr, 0);
    chk("midrst_oks", {c0_ok, c1_ok}, 0);
    chk("midrst_c0_data", c0_data, 0);
    chk("midrst_c1_data", c1_data, 0);
    @(negedge clk); rst = 1'b0; c1_cs = 1'b0;
    repeat (2) @(negedge clk);

    // Contention: both hold cs, stepping the address after each ok.
    sd_auto = 1'b1; sd_fixed = 1'b0;
    c0_addr = 18'h00100; c1_addr = 18'h00200; c0_cs = 1'b1; c1_cs = 1'b1;
    for (int i = 0; i < 4; i++) order[i] = -1;
    nord = 0; nrise = 0; prev_rs = 1'b0;
    for (int k = 0; k < 80 && nord < 4; k++) begin
      @(negedge clk);
      if (rom_cs && !prev_rs) nrise++;
      prev_rs = rom_cs;
      if (c0_ok) begin
        chk("cont_c0_data", c0_data, model_data(c0_addr));
        order[nord] = 0; nord++; c0_addr = c0_addr + 1'b1;
      end
      if (c1_ok) begin
        chk("cont_c1_data", c1_data, model_data(c1_addr));
        if (nord < 4) begin order[nord] = 1; nord++; end
        c1_addr = c1_addr + 1'b1;
      end
    end
    c0_cs = 1'b0; c1_cs = 1'b0;
    chk("cont_grant0", order[0], 0);
    chk("cont_grant1", order[1], 1);
    chk("cont_grant2", order[2], 0);
    chk("cont_grant3", order[3], 1);
    chk("cont_rom_cs_rises", nrise, 4);
    repeat (4) @(negedge clk);

    // Flush two cycles into WAIT, coinciding with rom_ok, then re-issue.
    sd_auto = 1'b0; man_ok = 1'b0;
    d0 = c0_data;
    @(negedge clk); c0_addr = 18'h00ABC; c0_cs = 1'b1;
    repeat (4) @(negedge clk);
    flush = 1'b1; man_ok = 1'b1; man_data = 32'h1111_1111;
    @(negedge clk);
    chk("flush_rom_cs", rom_cs, 0);
    chk("flush_no_ok_a", c0_ok, 0);
    @(negedge clk);
    chk("flush_no_ok_b", c0_ok, 0);
    chk("flush_data_kept", c0_data, d0);
    flush = 1'b0; man_ok = 1'b0;
    okc = -1; nrise = 0; seen = 1'b0; d = '0;
    for (int k = 1; k <= 15 && okc < 0; k++) begin
      @(negedge clk);
      if (c0_ok) begin
        okc = k; d = c0_data; c0_cs = 1'b0; man_ok = 1'b0;
      end else if (rom_cs) begin
        nrise++;
        if (nrise == 1) begin seen = 1'b1; chk("reissue_addr", rom_addr, 18'h00ABC); end
        if (nrise == 2) begin man_ok = 1'b1; man_data = 32'h2222_2222; end
      end
    end
    c0_cs = 1'b0; man_ok = 1'b0;
    chk("reissue_seen", seen, 1);
    chk("reissue_ok", okc > 0, 1);
    chk("reissue_data", d, 32'h2222_2222);
    sd_auto = 1'b1;
    repeat (4) @(negedge clk);

`ifdef JTBUBL_ROMARB_CACHE_EN
    // Cache: miss, hit without SDRAM traffic, then miss again after reset.
    sd_fixed = 1'b1; sd_fix_dly = 2; sd_fix_stale = 1'b0; sd_fix_data = 32'h5A5A_C3C3;
    txn(1, 18'h3FFFF, okc, d, nok, nother, rs1, ra1, rs_hi);
    chk("cache_miss_ok", okc, 4);
    chk("cache_miss_data", d, 32'h5A5A_C3C3);
    sd_fix_data = 32'h1234_5678;
    txn(1, 18'h3FFFF, okc, d, nok, nother, rs1, ra1, rs_hi);
    chk("cache_hit_ok", okc, 1);
    chk("cache_hit_rom_cs", rs_hi, 0);
    chk("cache_hit_data", d, 32'h5A5A_C3C3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    sd_fix_data = 32'h0BAD_CAFE;
    txn(1, 18'h3FFFF, okc, d, nok, nother, rs1, ra1, rs_hi);
    chk("cache_after_rst_ok", okc, 4);
    chk("cache_after_rst_rom", rs_hi > 0, 1);
    chk("cache_after_rst_data", d, 32'h0BAD_CAFE);
`endif

    // Randomized traffic against a transaction-level model.
    sd_fixed = 1'b0;
    for (int n = 0; n < 2; n++) begin
      pend[n] = 1'b0; start[n] = 0; byp[n] = 0; raddr[n] = '0;
`ifdef JTBUBL_ROMARB_CACHE_EN
      cvalid[n] = 1'b0; ctag[n] = '0;
`endif
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic served[2];
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        logic        okn;
        logic [31:0] dn;
        int          exp_min;
        served[n] = 1'b0;
        okn = (n == 0) ? c0_ok : c1_ok;
        dn  = (n == 0) ? c0_data : c1_data;
        if (okn) begin
          served[n] = 1'b1;
          chk("rnd_ok_with_req", pend[n], 1);
          if (pend[n]) begin
            exp_min = 3;
`ifdef JTBUBL_ROMARB_CACHE_EN
            if (cvalid[n] && ctag[n] == raddr[n]) exp_min = 1;
            cvalid[n] = 1'b1; ctag[n] = raddr[n];
`else
            if (pend[1-n]) begin
              byp[1-n]++;
              chk("rnd_fairness", byp[1-n] <= 1, 1);
            end
            byp[n] = 0;
`endif
            chk("rnd_data", dn, model_data(raddr[n]));
            chk("rnd_latency", (cyc - start[n]) >= exp_min, 1);
            pend[n] = 1'b0;
          end
        end else if (pend[n] && (cyc - start[n]) > 80) begin
          fail_now("rnd_timeout");
          pend[n] = 1'b0;
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && ($urandom_range(0, 3) < (served[n] ? 2 : 1))) begin
          pend[n]  = 1'b1;
          start[n] = cyc;
          raddr[n] = 18'h10000 + 18'($urandom_range(0, 7)) * 18'h111;
        end
      end
      c0_cs = pend[0]; c0_addr = raddr[0];
      c1_cs = pend[1]; c1_addr = raddr[1];
    end
    c0_cs = 1'b0; c1_cs = 1'b0;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
